regfile_wr_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file between two writeback requesters: ALU writeback (A) and load writeback (M). It holds a per-register pending-write scoreboard so decode can stall on RAW hazards against rs1/rs2. It sits between the writeback stages and the register file's rd/Write/readOrWrite inputs.

---
 rtl/regfile_wr_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin ALU/load writeback arbiter with RAW scoreboard; REGARB_FWD_EN adds forwarding
module regfile_wr_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_rd,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            m_valid,
  input  logic [AW-1:0]   m_rd,
  input  logic [DW-1:0]   m_data,
  output logic            m_ready,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            stall,
  output logic [NREG-1:0] busy,
`ifdef REGARB_FWD_EN
  output logic            fwd1_hit,
  output logic [DW-1:0]   fwd1_data,
  output logic            fwd2_hit,
  output logic [DW-1:0]   fwd2_data,
`endif
  output logic [AW-1:0]   rf_rd,
  output logic [DW-1:0]   rf_wdata,
  output logic            rf_rw
);
  typedef enum logic {GNT_A, GNT_M} gnt_e;
  gnt_e            last_grant_q, last_grant_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
  logic            rf_rw_q, rf_rw_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] clr, set;
  logic [AW-1:0]   w_rd;
  logic [DW-1:0]   w_data;
  logic            wr, hit1, hit2;
  // State register: arbiter history, output stage and scoreboard
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= GNT_M;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
      rf_rw_q      <= 1'b1;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_rw_q      <= rf_rw_d;
      busy_q       <= busy_d;
    end
  end
  // Next state: latch the granted write (x0 is swallowed), clear then reserve so reserve wins
  always_comb begin
    w_rd         = a_ready ? a_rd : m_rd;
    w_data       = a_ready ? a_data : m_data;
    wr           = (a_ready | m_ready) & (w_rd != '0);
    last_grant_d = a_ready ? GNT_A : m_ready ? GNT_M : last_grant_q;
    rf_rw_d      = ~wr;
    rf_rd_d      = wr ? w_rd : rf_rd_q;
    rf_wdata_d   = wr ? w_data : rf_wdata_q;
    clr          = wr ? (NREG'(1) << w_rd) : '0;
    set          = (rsv_valid && rsv_rd != '0) ? (NREG'(1) << rsv_rd) : '0;
    busy_d       = ((busy_q & ~clr) | set) & ~NREG'(1);
  end
  // Grant outputs: single requester wins outright, a tie goes to the one not granted last
  always_comb begin
    a_ready = rst & ~hold & a_valid & (~m_valid | (last_grant_q == GNT_M));
    m_ready = rst & ~hold & m_valid & (~a_valid | (last_grant_q == GNT_A));
  end
`ifdef REGARB_FWD_EN
  // Forwarding: the register being written this cycle satisfies a matching source read
  always_comb begin
    hit1      = ~rf_rw_q & (rf_rd_q == rs1) & (rs1 != '0);
    hit2      = ~rf_rw_q & (rf_rd_q == rs2) & (rs2 != '0);
    fwd1_hit  = hit1;
    fwd2_hit  = hit2;
    fwd1_data = rf_wdata_q;
    fwd2_data = rf_wdata_q;
  end
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  assign stall    = (busy_q[rs1] & ~hit1) | (busy_q[rs2] & ~hit2);
  assign busy     = busy_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_rw    = rf_rw_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed stimulus checked against a per-cycle behavioural model
module tb_regfile_wr_arbiter;
  logic        clk = 0, rst = 0, hold = 0;
  logic        a_valid = 0, m_valid = 0, rsv_valid = 0;
  logic [4:0]  a_rd = 0, m_rd = 0, rsv_rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] a_data = 0, m_data = 0;
  logic        a_ready, m_ready, stall, rf_rw;
  logic [31:0] busy, rf_wdata;
  logic [4:0]  rf_rd;
`ifdef REGARB_FWD_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
`endif
  int total = 0, bad = 0;

  regfile_wr_arbiter dut (
    .clk(clk), .rst(rst), .hold(hold),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rs1(rs1), .rs2(rs2),
    .stall(stall), .busy(busy),
`ifdef REGARB_FWD_EN
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
`endif
    .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_rw(rf_rw)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  // model state: who won last (0 = ALU, 1 = load), pending set, last write seen by the file
  bit          started = 0;
  int          lg = 1;
  bit          mb[32];
  logic [4:0]  mrd = 0;
  logic [31:0] mwd = 0;
  bit          mrw = 1;

  function automatic void grants(output bit ga, output bit gm);
    ga = 0;
    gm = 0;
    if (rst && !hold) begin
      if (a_valid && m_valid) begin
        ga = (lg == 1);
        gm = !ga;
      end else begin
        ga = a_valid;
        gm = m_valid;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit ga, gm;
    int rd;
    logic [31:0] d;
    if (!rst) begin
      started = 1;
      lg = 1;
      foreach (mb[i]) mb[i] = 0;
      mrd = 0;
      mwd = 0;
      mrw = 1;
    end else begin
      grants(ga, gm);
      mrw = 1;
      if (ga || gm) begin
        rd = ga ? int'(a_rd) : int'(m_rd);
        d  = ga ? a_data : m_data;
        lg = ga ? 0 : 1;
        if (rd != 0) begin
          mrw = 0;
          mrd = rd[4:0];
          mwd = d;
          mb[rd] = 0;
        end
      end
      if (rsv_valid && rsv_rd != 0) mb[rsv_rd] = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit ga, gm, h1, h2, es;
      logic [31:0] bv;
      grants(ga, gm);
      bv = 0;
      for (int i = 0; i < 32; i++) bv[i] = mb[i];
`ifdef REGARB_FWD_EN
      h1 = !mrw && mrd == rs1 && rs1 != 0;
      h2 = !mrw && mrd == rs2 && rs2 != 0;
      chk("m_fwd1_hit", fwd1_hit, h1);
      chk("m_fwd2_hit", fwd2_hit, h2);
      if (h1) chk("m_fwd1_data", fwd1_data, mwd);
`else
      h1 = 0;
      h2 = 0;
`endif
      es = (mb[rs1] && !h1) || (mb[rs2] && !h2);
      chk("m_a_ready", a_ready, ga);
      chk("m_m_ready", m_ready, gm);
      chk("m_busy", busy, bv);
      chk("m_stall", stall, es);
      chk("m_rf_rw", rf_rw, mrw);
      chk("m_rf_rd", rf_rd, mrd);
      chk("m_rf_wdata", rf_wdata, mwd);
    end
  end

  initial begin
    a_valid = 1; a_rd = 1; a_data = 9;
    cyc; cyc; #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_rf_rw", rf_rw, 1);
    chk("rst_busy", busy, 0);
    rst = 1; m_valid = 1; m_rd = 2; m_data = 3; #1;
    chk("tie_a_ready", a_ready, 1);
    chk("tie_m_ready", m_ready, 0);
    cyc; a_valid = 0; m_valid = 0;
    chk("first_rd", rf_rd, 1);
    chk("first_wdata", rf_wdata, 9);
    chk("first_rw", rf_rw, 0);
    rsv_valid = 1; rsv_rd = 7; cyc;
    rsv_valid = 0; a_valid = 1; a_rd = 7; a_data = 10; #1;
    chk("sw_busy7", busy[7], 1);
    chk("sw_a_ready", a_ready, 1);
    cyc; a_valid = 0;
    chk("sw_rw", rf_rw, 0);
    chk("sw_rd", rf_rd, 7);
    chk("sw_wdata", rf_wdata, 10);
    chk("sw_busy7_clr", busy[7], 0);
    cyc;
    chk("idle_rw", rf_rw, 1);
    chk("idle_rd", rf_rd, 7);
    m_valid = 1; m_rd = 5; m_data = 6; cyc; m_valid = 0;
    a_valid = 1; a_rd = 3; a_data = 1; m_valid = 1; m_rd = 4; m_data = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
      cyc;
      chk("rr_rw", rf_rw, 0);
      chk("rr_rd", rf_rd, (i % 2 == 0) ? 3 : 4);
    end
    a_valid = 0; m_valid = 0;
    m_valid = 1; m_rd = 0; m_data = 5; #1;
    chk("x0_m_ready", m_ready, 1);
    cyc; m_valid = 0;
    chk("x0_rw", rf_rw, 1);
    chk("x0_rd", rf_rd, 4);
    chk("x0_wdata", rf_wdata, 2);
    a_valid = 1; a_rd = 8; a_data = 2; cyc; a_valid = 0;
    chk("ax_rd", rf_rd, 8);
    chk("ax_wdata", rf_wdata, 2);
    chk("ax_rw", rf_rw, 0);
    rsv_valid = 1; rsv_rd = 8; rs2 = 8; cyc; rsv_valid = 0;
    chk("hz_stall", stall, 1);
    rsv_valid = 1; m_valid = 1; m_rd = 8; m_data = 77; cyc; rsv_valid = 0; m_valid = 0;
    chk("col_busy8", busy[8], 1);
    chk("col_rw", rf_rw, 0);
    chk("col_wdata", rf_wdata, 77);
    hold = 1; a_valid = 1; a_rd = 9; a_data = 4; m_valid = 1; m_rd = 10; m_data = 5; #1;
    chk("hold_a_ready", a_ready, 0);
    chk("hold_m_ready", m_ready, 0);
    cyc;
    chk("hold_stall", stall, 1);
    chk("hold_rw", rf_rw, 1);
    cyc;
    chk("hold_stall2", stall, 1);
    chk("hold_m_ready2", m_ready, 0);
    hold = 0; m_valid = 0; rsv_valid = 1; rsv_rd = 12; cyc;
    a_valid = 0; rsv_valid = 0;
    chk("mid_rw", rf_rw, 0);
    chk("mid_busy12", busy[12], 1);
    rst = 0; cyc;
    chk("rstmid_rw", rf_rw, 1);
    chk("rstmid_busy", busy, 0);
    rst = 1; cyc; cyc;
    chk("post_rw", rf_rw, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
